// File: rtl/fractal_sync_pkg.sv
// Shared types for the fractal sync barrier transmitter:
// FSM state encoding and the 2-bit completion code.
package fractal_sync_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SEND = 2'b01,
        ST_WAIT = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_ID      = 2'b01,
        ERR_SIG     = 2'b10,
        ERR_TIMEOUT = 2'b11
    } err_e;

    localparam int CNT_WIDTH = 16;

endpackage

// File: rtl/fractal_sync_tx_timer.sv
// WAIT-state watchdog: cleared on WAIT entry, counts while enabled,
// flags expiry in the cycle that completes TIMEOUT_CYCLES of waiting.
module fractal_sync_tx_timer
    import fractal_sync_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [CNT_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            cnt_q <= '0;
        end else if (en_i && !expired_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/fractal_sync_tx.sv
// Barrier request transmitter: one outstanding barrier from core to sync net.
// Optional WAIT timeout under macro FRACTAL_SYNC_TIMEOUT_EN.
module fractal_sync_tx
    import fractal_sync_pkg::*;
#(
    parameter int LEVEL_WIDTH    = 1,
    parameter int ID_WIDTH       = 1,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   core_req_valid_i,
    output logic                   core_req_ready_o,
    input  logic [LEVEL_WIDTH-1:0] core_level_i,
    input  logic [ID_WIDTH-1:0]    core_id_i,
    output logic                   core_rsp_valid_o,
    input  logic                   core_rsp_ready_i,
    output logic [1:0]             core_rsp_err_o,
    output logic                   net_req_valid_o,
    input  logic                   net_req_ready_i,
    output logic [LEVEL_WIDTH-1:0] net_level_o,
    output logic [ID_WIDTH-1:0]    net_id_o,
    input  logic                   net_rsp_valid_i,
    input  logic [LEVEL_WIDTH-1:0] net_rsp_level_i,
    input  logic [ID_WIDTH-1:0]    net_rsp_id_i,
    input  logic                   net_rsp_wake_i,
    input  logic                   net_rsp_id_err_i,
    input  logic                   net_rsp_sig_err_i,
    output logic                   busy_o,
    output logic                   stray_o
);

    state_e               state_q, state_d;
    err_e                 err_q, err_d;
    logic [LEVEL_WIDTH-1:0] level_q;
    logic [ID_WIDTH-1:0]  id_q;
    logic                 cap_en;
    logic                 timer_clr;
    logic                 timer_en;
    logic                 timeout_hit;
    logic                 rsp_match;
    logic                 taken;
    logic                 req_valid;
    logic                 rsp_valid;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            err_q   <= ERR_OK;
            level_q <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (cap_en) begin
                level_q <= core_level_i;
                id_q    <= core_id_i;
            end
        end
    end

    assign rsp_match = net_rsp_valid_i
                    && (net_rsp_level_i == level_q)
                    && (net_rsp_id_i == id_q);

    always_comb begin
        state_d          = state_q;
        err_d            = err_q;
        cap_en           = 1'b0;
        timer_clr        = 1'b0;
        timer_en         = 1'b0;
        taken            = 1'b0;
        req_valid        = 1'b0;
        rsp_valid        = 1'b0;
        core_req_ready_o = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                core_req_ready_o = 1'b1;
                if (core_req_valid_i) begin
                    cap_en  = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                req_valid = 1'b1;
                if (net_req_ready_i) begin
                    timer_clr = 1'b1;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                timer_en = 1'b1;
                // A match with neither wake nor error is consumed silently.
                taken    = rsp_match;
                if (rsp_match && net_rsp_id_err_i) begin
                    err_d   = ERR_ID;
                    state_d = ST_DONE;
                end else if (rsp_match && net_rsp_sig_err_i) begin
                    err_d   = ERR_SIG;
                    state_d = ST_DONE;
                end else if (rsp_match && net_rsp_wake_i) begin
                    err_d   = ERR_OK;
                    state_d = ST_DONE;
                end else if (timeout_hit) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                rsp_valid = 1'b1;
                if (core_rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef FRACTAL_SYNC_TIMEOUT_EN
    fractal_sync_tx_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (timer_clr),
        .en_i     (timer_en),
        .expired_o(timeout_hit)
    );
`else
    logic unused_timer;
    assign timeout_hit  = 1'b0;
    assign unused_timer = timer_clr ^ timer_en ^ (TIMEOUT_CYCLES == 0);
`endif

    // A reset cycle abandons the barrier without any visible handshake.
    assign net_req_valid_o  = req_valid && !rst_i;
    assign core_rsp_valid_o = rsp_valid && !rst_i;
    assign stray_o          = net_rsp_valid_i && !taken && !rst_i;
    assign core_rsp_err_o   = (state_q == ST_DONE) ? err_q : ERR_OK;
    assign net_level_o      = level_q;
    assign net_id_o         = id_q;
    assign busy_o           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fractal_sync_tx.sv
// Directed self-checking bench for fractal_sync_tx (1-bit level/id,
// TIMEOUT_CYCLES=4); timeout scenarios follow FRACTAL_SYNC_TIMEOUT_EN.
module tb_fractal_sync_tx;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       core_req_valid_i;
    logic       core_req_ready_o;
    logic [0:0] core_level_i;
    logic [0:0] core_id_i;
    logic       core_rsp_valid_o;
    logic       core_rsp_ready_i;
    logic [1:0] core_rsp_err_o;
    logic       net_req_valid_o;
    logic       net_req_ready_i;
    logic [0:0] net_level_o;
    logic [0:0] net_id_o;
    logic       net_rsp_valid_i;
    logic [0:0] net_rsp_level_i;
    logic [0:0] net_rsp_id_i;
    logic       net_rsp_wake_i;
    logic       net_rsp_id_err_i;
    logic       net_rsp_sig_err_i;
    logic       busy_o;
    logic       stray_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fractal_sync_tx #(
        .LEVEL_WIDTH(1),
        .ID_WIDTH(1),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .core_req_valid_i (core_req_valid_i),
        .core_req_ready_o (core_req_ready_o),
        .core_level_i     (core_level_i),
        .core_id_i        (core_id_i),
        .core_rsp_valid_o (core_rsp_valid_o),
        .core_rsp_ready_i (core_rsp_ready_i),
        .core_rsp_err_o   (core_rsp_err_o),
        .net_req_valid_o  (net_req_valid_o),
        .net_req_ready_i  (net_req_ready_i),
        .net_level_o      (net_level_o),
        .net_id_o         (net_id_o),
        .net_rsp_valid_i  (net_rsp_valid_i),
        .net_rsp_level_i  (net_rsp_level_i),
        .net_rsp_id_i     (net_rsp_id_i),
        .net_rsp_wake_i   (net_rsp_wake_i),
        .net_rsp_id_err_i (net_rsp_id_err_i),
        .net_rsp_sig_err_i(net_rsp_sig_err_i),
        .busy_o           (busy_o),
        .stray_o          (stray_o)
    );

    // Inputs change 1ns after the rising edge; checks run 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rsp(input logic v, input logic lv, input logic id,
                       input logic wk, input logic ie, input logic se);
        net_rsp_valid_i   = v;
        net_rsp_level_i   = lv;
        net_rsp_id_i      = id;
        net_rsp_wake_i    = wk;
        net_rsp_id_err_i  = ie;
        net_rsp_sig_err_i = se;
    endtask

    // Returns at cycle W, the first cycle in WAIT.
    task automatic start_barrier(input logic lv, input logic id);
        core_req_valid_i = 1'b1;
        core_level_i     = lv;
        core_id_i        = id;
        step();
        core_req_valid_i = 1'b0;
        net_req_ready_i  = 1'b1;
        step();
        net_req_ready_i  = 1'b0;
    endtask

    task automatic finish_done();
        core_rsp_ready_i = 1'b1;
        step();
        core_rsp_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        #1;
        checks++;
        if (core_req_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_req_ready got=%b exp=1", core_req_ready_o);
        end
        checks++;
        if (core_rsp_valid_o !== 1'b0 || core_rsp_err_o !== 2'b00) begin
            errors++;
            $display("FAIL reset_rsp got v=%b e=%b exp v=0 e=00",
                     core_rsp_valid_o, core_rsp_err_o);
        end
        checks++;
        if (net_req_valid_o !== 1'b0 || net_level_o !== 1'b0 || net_id_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_net got v=%b l=%b i=%b exp 0 0 0",
                     net_req_valid_o, net_level_o, net_id_o);
        end
        checks++;
        if (busy_o !== 1'b0 || stray_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy_stray got b=%b s=%b exp 0 0", busy_o, stray_o);
        end
    endtask

    task automatic test_send_stall();
        step();
        core_req_valid_i = 1'b1;
        core_level_i     = 1'b1;
        core_id_i        = 1'b0;
        #1;
        checks++;
        if (core_req_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_accept got=%b exp=1", core_req_ready_o);
        end
        step();
        core_req_valid_i = 1'b0;
        core_level_i     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            net_req_ready_i = (i == 3);
            #1;
            checks++;
            if (net_req_valid_o !== 1'b1 || net_level_o !== 1'b1 ||
                net_id_o !== 1'b0 || core_req_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL stall_send[%0d] got v=%b l=%b i=%b rdy=%b exp 1 1 0 0",
                         i, net_req_valid_o, net_level_o, net_id_o, core_req_ready_o);
            end
            step();
        end
        net_req_ready_i = 1'b0;
        #1;
        checks++;
        if (net_req_valid_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_wait got v=%b b=%b exp v=0 b=1", net_req_valid_o, busy_o);
        end
        rsp(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (stray_o !== 1'b0 || core_rsp_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_match got s=%b v=%b exp 0 0", stray_o, core_rsp_valid_o);
        end
        step();
        rsp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (core_rsp_valid_o !== 1'b1 || core_rsp_err_o !== 2'b00) begin
            errors++;
            $display("FAIL stall_done got v=%b e=%b exp v=1 e=00",
                     core_rsp_valid_o, core_rsp_err_o);
        end
        finish_done();
        checks++;
        if (busy_o !== 1'b0 || core_req_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_idle got b=%b r=%b exp 0 1", busy_o, core_req_ready_o);
        end
    endtask

    task automatic test_mismatch();
        start_barrier(1'b1, 1'b0);
        rsp(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (stray_o !== 1'b1) begin
            errors++;
            $display("FAIL mm_id_stray got=%b exp=1", stray_o);
        end
        step();
        rsp(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (stray_o !== 1'b1 || busy_o !== 1'b1 || core_rsp_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL mm_lvl got s=%b b=%b v=%b exp 1 1 0",
                     stray_o, busy_o, core_rsp_valid_o);
        end
        step();
        rsp(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (stray_o !== 1'b0 || core_rsp_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL mm_ignored got s=%b v=%b exp 0 0", stray_o, core_rsp_valid_o);
        end
        step();
        rsp(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        #1;
        checks++;
        if (core_rsp_valid_o !== 1'b0 || stray_o !== 1'b0) begin
            errors++;
            $display("FAIL mm_still_wait got v=%b s=%b exp 0 0", core_rsp_valid_o, stray_o);
        end
        step();
        rsp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (core_rsp_valid_o !== 1'b1 || core_rsp_err_o !== 2'b01) begin
            errors++;
            $display("FAIL mm_id_err got v=%b e=%b exp v=1 e=01",
                     core_rsp_valid_o, core_rsp_err_o);
        end
        finish_done();
    endtask

    task automatic test_sig_err();
        start_barrier(1'b0, 1'b1);
        rsp(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        rsp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (core_rsp_valid_o !== 1'b1 || core_rsp_err_o !== 2'b10) begin
            errors++;
            $display("FAIL sig_err got v=%b e=%b exp v=1 e=10",
                     core_rsp_valid_o, core_rsp_err_o);
        end
        finish_done();
    endtask

    task automatic test_done_hold();
        start_barrier(1'b1, 1'b1);
        rsp(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        rsp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        core_req_valid_i = 1'b1;
        core_level_i     = 1'b0;
        core_id_i        = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (core_rsp_valid_o !== 1'b1 || core_rsp_err_o !== 2'b00 ||
                core_req_ready_o !== 1'b0 || net_req_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d] got v=%b e=%b r=%b n=%b exp 1 00 0 0",
                         i, core_rsp_valid_o, core_rsp_err_o,
                         core_req_ready_o, net_req_valid_o);
            end
            step();
        end
        core_req_valid_i = 1'b0;
        rsp(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (stray_o !== 1'b1) begin
            errors++;
            $display("FAIL hold_done_stray got=%b exp=1", stray_o);
        end
        rsp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        finish_done();
        checks++;
        if (busy_o !== 1'b0 || net_req_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL hold_idle got b=%b n=%b exp 0 0", busy_o, net_req_valid_o);
        end
        rsp(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (stray_o !== 1'b1) begin
            errors++;
            $display("FAIL idle_stray got=%b exp=1", stray_o);
        end
        rsp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
`ifdef FRACTAL_SYNC_TIMEOUT_EN
        start_barrier(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (core_rsp_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL to_early[%0d] got=%b exp=0", i, core_rsp_valid_o);
            end
            step();
        end
        #1;
        checks++;
        if (core_rsp_valid_o !== 1'b1 || core_rsp_err_o !== 2'b11) begin
            errors++;
            $display("FAIL to_expire got v=%b e=%b exp v=1 e=11",
                     core_rsp_valid_o, core_rsp_err_o);
        end
        finish_done();
        rsp(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (stray_o !== 1'b1) begin
            errors++;
            $display("FAIL to_late_stray got=%b exp=1", stray_o);
        end
        rsp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        start_barrier(1'b1, 1'b0);
        step();
        step();
        step();
        rsp(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        rsp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (core_rsp_valid_o !== 1'b1 || core_rsp_err_o !== 2'b00) begin
            errors++;
            $display("FAIL to_race got v=%b e=%b exp v=1 e=00",
                     core_rsp_valid_o, core_rsp_err_o);
        end
        finish_done();
`else
        start_barrier(1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            #1;
            checks++;
            if (core_rsp_valid_o !== 1'b0 || busy_o !== 1'b1) begin
                errors++;
                $display("FAIL no_to[%0d] got v=%b b=%b exp 0 1",
                         i, core_rsp_valid_o, busy_o);
            end
            step();
        end
        rsp(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        rsp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (core_rsp_valid_o !== 1'b1 || core_rsp_err_o !== 2'b00) begin
            errors++;
            $display("FAIL no_to_wake got v=%b e=%b exp v=1 e=00",
                     core_rsp_valid_o, core_rsp_err_o);
        end
        finish_done();
`endif
    endtask

    task automatic test_reset_mid();
        start_barrier(1'b1, 1'b1);
        rst_i = 1'b1;
        rsp(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (stray_o !== 1'b0 || core_rsp_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait_cycle got s=%b v=%b exp 0 0", stray_o, core_rsp_valid_o);
        end
        step();
        rst_i = 1'b0;
        rsp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (core_req_ready_o !== 1'b1 || core_rsp_valid_o !== 1'b0 ||
            core_rsp_err_o !== 2'b00 || net_req_valid_o !== 1'b0 ||
            net_level_o !== 1'b0 || net_id_o !== 1'b0 ||
            busy_o !== 1'b0 || stray_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_outs got r=%b v=%b e=%b n=%b l=%b i=%b b=%b s=%b exp 1 0 00 0 0 0 0 0",
                     core_req_ready_o, core_rsp_valid_o, core_rsp_err_o,
                     net_req_valid_o, net_level_o, net_id_o, busy_o, stray_o);
        end
        rsp(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (stray_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_stray got=%b exp=1", stray_o);
        end
        step();
        rsp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        start_barrier(1'b0, 1'b0);
        rsp(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        rsp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_i = 1'b1;
        #1;
        checks++;
        if (core_rsp_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_done_cycle got=%b exp=0", core_rsp_valid_o);
        end
        step();
        rst_i = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || core_rsp_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_done_after got b=%b v=%b exp 0 0", busy_o, core_rsp_valid_o);
        end
    endtask

    initial begin
        rst_i            = 1'b1;
        core_req_valid_i = 1'b0;
        core_level_i     = 1'b0;
        core_id_i        = 1'b0;
        core_rsp_ready_i = 1'b0;
        net_req_ready_i  = 1'b0;
        rsp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_send_stall();
        test_mismatch();
        test_sig_err();
        test_done_hold();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
